multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle MIPS control FSM for the single shared-memory datapath.
//  - Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, one datapath step per clk.
//  - Drives all datapath enables and mux selects from the current state.
//  - Stalls on a variable-latency memory through a mem_ready handshake.
//  - Opcodes: R-format, lw, sw, beq, addi, andi, ori, jal.
// PARAMETERS
//  OPCODE_W  6  opcode width
//  ALUOP_W   3  ALUOp width. Codes: 000 add, 001 sub, 010 use funct, 100 and, 101 or
// PORTS
//  clk          in   1        single clock; all state changes on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  opcode       in   OPCODE_W instruction[31:26] from the IR; sampled in DECODE only
//  mem_ready    in   1        memory completes the current MemRead/MemWrite this cycle
//  PCWrite      out  1        unconditional PC load
//  PCWriteCond  out  1        PC load if ALU zero (beq)
//  IorD         out  1        memory address: 0 = PC, 1 = ALUOut
//  MemRead      out  1        memory read request
//  MemWrite     out  1        memory write request
//  IRWrite      out  1        IR load
//  RegDst       out  2        00 = rt, 01 = rd, 10 = $31
//  MemToReg     out  2        00 = ALUOut, 01 = MDR, 10 = PC
//  RegWrite     out  1        register-file write
//  ALUSrcA      out  1        0 = PC, 1 = rs
//  ALUSrcB      out  2        00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
//  ALUOp        out  ALUOP_W  ALU operation code
//  PCSource     out  2        00 = ALU result, 01 = ALUOut, 10 = jump target
//  instr_done   out  1        one-cycle pulse on the final cycle of every instruction
//  illegal_op   out  1        sticky illegal-opcode flag (ILLEGAL_OP_TRAP_EN builds only, else tied 0)
// BEHAVIOUR
//  - Output decode: Moore. Outputs depend on state only, except that every memory-completion
//    strobe is additionally gated by mem_ready.
//  - Reset: state <= S_RESET. In S_RESET every output is 0. S_RESET -> S_FETCH unconditionally.
//  - Reset asserted mid-instruction: the state is abandoned immediately. No partial write
//    may complete after rst_n falls.
//  - S_FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
//    IRWrite = PCWrite = mem_ready. Stays in S_FETCH while !mem_ready; advances to S_DECODE.
//  - S_DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by opcode:
//    lw/sw -> S_MADDR; R -> S_REXEC; beq -> S_BEQ; addi/andi/ori -> S_IEXEC; jal -> S_JAL.
//  - S_MADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=add. lw -> S_MRD, sw -> S_MWR.
//  - S_MRD: MemRead=1, IorD=1. Waits on mem_ready, then -> S_MWB.
//  - S_MWB: RegDst=00, MemToReg=01, RegWrite=1, instr_done=1. -> S_FETCH.
//  - S_MWR: MemWrite=1, IorD=1. Waits on mem_ready; on the ready cycle instr_done=1, -> S_FETCH.
//  - S_REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. -> S_RWB.
//  - S_RWB: RegDst=01, MemToReg=00, RegWrite=1, instr_done=1. -> S_FETCH.
//  - S_BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01, instr_done=1. -> S_FETCH.
//  - S_IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp = add (addi) / and (andi) / or (ori).
//    The ALUOp selection is registered in S_DECODE. -> S_IWB.
//  - S_IWB: RegDst=00, MemToReg=00, RegWrite=1, instr_done=1. -> S_FETCH.
//  - S_JAL: RegDst=10, MemToReg=10, RegWrite=1, PCSource=10, PCWrite=1, instr_done=1. -> S_FETCH.
//    $31 receives PC+4 because the PC was already incremented in S_FETCH.
//  - Latency with zero-wait memory, in cycles:
//    lw 5, sw 4, R 4, addi/andi/ori 4, beq 3, jal 3. Each mem_ready wait adds 1.
//  - Every unnamed output is 0 in every state. No X outputs are ever driven.
// CONFIGURATION
//  - ILLEGAL_OP_TRAP_EN defined:
//    - An unknown opcode in S_DECODE -> S_TRAP. S_TRAP is terminal: all enables 0, illegal_op=1.
//    - The state is left only through rst_n.
//  - ILLEGAL_OP_TRAP_EN undefined:
//    - An unknown opcode executes as a NOP: S_DECODE -> S_FETCH with instr_done=1.
//    - illegal_op is tied to 0.
// STRUCTURE
//  - Package mips_ctrl_pkg holds: opcode constants, ALUOp codes, the RegDst/MemToReg/ALUSrcB/
//    PCSource encodings, and the state enum.
//  - One sub-module, mcu_output_decode: combinational state -> control-word decoder.
//    The FSM register and next-state logic stay in this module.
// TESTING
//  - Reset: rst_n low mid-S_MRD -> next cycle all outputs 0 and state S_RESET.
//    After release, S_FETCH one cycle later.
//  - lw (opcode 100011), mem_ready held high: states FETCH, DECODE, MADDR, MRD, MWB.
//    RegWrite=1 and MemToReg=01 only in cycle 5; instr_done in cycle 5.
//  - sw (opcode 101011), mem_ready low for 3 cycles in S_MWR: MemWrite held for 4 cycles.
//    instr_done only on the ready cycle; RegWrite never 1.
//  - beq (opcode 000100): PCWriteCond=1, ALUOp=001, PCSource=01 in cycle 3 only; PCWrite=0 there.
//  - ori then jal (opcodes 001101, 000011): ALUOp=101 in S_IEXEC.
//    S_JAL drives RegDst=10, MemToReg=10, PCSource=10, PCWrite=1.
//  - Opcode 111111: with ILLEGAL_OP_TRAP_EN, illegal_op=1 persists until reset.
//    Without it, instr_done in cycle 2, then back to S_FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALUOp codes,
// datapath mux selects and the FSM state enum.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MADDR,
        S_MRD,
        S_MWB,
        S_MWR,
        S_REXEC,
        S_RWB,
        S_BEQ,
        S_IEXEC,
        S_IWB,
        S_JAL,
        S_TRAP
    } state_t;

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational state -> control-word decoder. Memory-completion strobes are gated
// by mem_ready; illegal_op is only driven in ILLEGAL_OP_TRAP_EN builds.
module mcu_output_decode
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  state_t             state,
    input  logic               mem_ready,
    input  logic               decode_nop,
    input  logic [ALUOP_W-1:0] imm_aluop,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               illegal_op
);

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = REGDST_RT;
        MemToReg    = M2R_ALUOUT;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_W'(ALU_ADD);
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMMSH;
                instr_done = decode_nop;
            end
            S_MADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MWB: begin
                MemToReg   = M2R_MDR;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(ALU_FUNCT);
            end
            S_RWB: begin
                RegDst     = REGDST_RD;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(ALU_SUB);
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = imm_aluop;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            // $31 gets the PC already advanced by FETCH, i.e. PC+4
            S_JAL: begin
                RegDst     = REGDST_R31;
                MemToReg   = M2R_PC;
                RegWrite   = 1'b1;
                PCSource   = PCSRC_JUMP;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: illegal_op = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: state register, next-state logic and decode-time
// operand registers. Build with ILLEGAL_OP_TRAP_EN to trap unknown opcodes.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemToReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic                instr_done,
    output logic                illegal_op
);

    state_t             state, state_nxt;
    logic               mem_is_store, mem_is_store_nxt;
    logic [ALUOP_W-1:0] imm_aluop, imm_aluop_nxt;
    logic               decode_nop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RESET;
            mem_is_store <= 1'b0;
            imm_aluop    <= '0;
        end else begin
            state        <= state_nxt;
            mem_is_store <= mem_is_store_nxt;
            imm_aluop    <= imm_aluop_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        mem_is_store_nxt = mem_is_store;
        imm_aluop_nxt    = imm_aluop;
        decode_nop       = 1'b0;
        case (state)
            S_RESET:  state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            // opcode is only trusted here; anything later needs it latched
            S_DECODE: begin
                case (opcode)
                    OPCODE_W'(OP_LW): begin
                        state_nxt        = S_MADDR;
                        mem_is_store_nxt = 1'b0;
                    end
                    OPCODE_W'(OP_SW): begin
                        state_nxt        = S_MADDR;
                        mem_is_store_nxt = 1'b1;
                    end
                    OPCODE_W'(OP_RTYPE): state_nxt = S_REXEC;
                    OPCODE_W'(OP_BEQ):   state_nxt = S_BEQ;
                    OPCODE_W'(OP_ADDI): begin
                        state_nxt     = S_IEXEC;
                        imm_aluop_nxt = ALUOP_W'(ALU_ADD);
                    end
                    OPCODE_W'(OP_ANDI): begin
                        state_nxt     = S_IEXEC;
                        imm_aluop_nxt = ALUOP_W'(ALU_AND);
                    end
                    OPCODE_W'(OP_ORI): begin
                        state_nxt     = S_IEXEC;
                        imm_aluop_nxt = ALUOP_W'(ALU_OR);
                    end
                    OPCODE_W'(OP_JAL):   state_nxt = S_JAL;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_nxt = S_TRAP;
`else
                        state_nxt  = S_FETCH;
                        decode_nop = 1'b1;
`endif
                    end
                endcase
            end
            S_MADDR:  state_nxt = mem_is_store ? S_MWR : S_MRD;
            S_MRD:    if (mem_ready) state_nxt = S_MWB;
            S_MWB:    state_nxt = S_FETCH;
            S_MWR:    if (mem_ready) state_nxt = S_FETCH;
            S_REXEC:  state_nxt = S_RWB;
            S_RWB:    state_nxt = S_FETCH;
            S_BEQ:    state_nxt = S_FETCH;
            S_IEXEC:  state_nxt = S_IWB;
            S_IWB:    state_nxt = S_FETCH;
            S_JAL:    state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_RESET;
        endcase
    end

    mcu_output_decode #(
        .ALUOP_W(ALUOP_W)
    ) u_decode (
        .state       (state),
        .mem_ready   (mem_ready),
        .decode_nop  (decode_nop),
        .imm_aluop   (imm_aluop),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemToReg    (MemToReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: expected control words are queued
// per cycle and compared on the falling edge. Honours ILLEGAL_OP_TRAP_EN.
module tb_multicycle_control_unit;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] RegDst, MemToReg;
    logic       RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done, illegal_op;

    int checks = 0;
    int errors = 0;

    logic [20:0] exp_q[$];
    string       tag_q[$];

    localparam logic [5:0] JUNK = 6'b111111;

    multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // word layout: pcw pcwc iord mrd mwr irw regdst m2r rw srca srcb aluop pcsrc done ill
    function automatic logic [20:0] cw(input logic pcw, input logic pcwc, input logic iord,
                                       input logic mrd, input logic mwr, input logic irw,
                                       input logic [1:0] rdst, input logic [1:0] m2r,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [2:0] aop, input logic [1:0] pcs,
                                       input logic done, input logic ill);
        return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, done, ill};
    endfunction

    function automatic logic [20:0] e_zero();
        return '0;
    endfunction
    function automatic logic [20:0] e_fetch(input logic mr);
        return cw(mr, 0, 0, 1, 0, mr, 2'b00, 2'b00, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0);
    endfunction
    function automatic logic [20:0] e_decode(input logic nop);
        return cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 3'b000, 2'b00, nop, 0);
    endfunction
    function automatic logic [20:0] e_maddr();
        return cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0);
    endfunction
    function automatic logic [20:0] e_mrd();
        return cw(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    endfunction
    function automatic logic [20:0] e_mwb();
        return cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 3'b000, 2'b00, 1, 0);
    endfunction
    function automatic logic [20:0] e_mwr(input logic mr);
        return cw(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00, mr, 0);
    endfunction
    function automatic logic [20:0] e_rexec();
        return cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0);
    endfunction
    function automatic logic [20:0] e_rwb();
        return cw(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 3'b000, 2'b00, 1, 0);
    endfunction
    function automatic logic [20:0] e_beq();
        return cw(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b001, 2'b01, 1, 0);
    endfunction
    function automatic logic [20:0] e_iexec(input logic [2:0] aop);
        return cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, aop, 2'b00, 0, 0);
    endfunction
    function automatic logic [20:0] e_iwb();
        return cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 3'b000, 2'b00, 1, 0);
    endfunction
    function automatic logic [20:0] e_jal();
        return cw(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 3'b000, 2'b10, 1, 0);
    endfunction
    function automatic logic [20:0] e_trap();
        return cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1);
    endfunction

    task automatic compare_out();
        logic [20:0] obs, exp_w;
        string       tag;
        obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};
        exp_w = exp_q.pop_front();
        tag   = tag_q.pop_front();
        checks++;
        assert (obs === exp_w) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_w);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic mr, input logic [20:0] e,
                        input string tag);
        opcode    = op;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state_reset(input string tag);
        checks++;
        assert (dut.state === S_RESET) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, dut.state, S_RESET);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = JUNK;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(JUNK, 1, e_zero(), "reset_hold");
        check_state_reset("reset_state");
        rst_n = 1'b1;
        step(JUNK, 1, e_zero(), "reset_release");

        // lw, zero-wait
        step(JUNK,  1, e_fetch(1),    "lw_fetch");
        step(OP_LW, 1, e_decode(0),   "lw_decode");
        step(JUNK,  1, e_maddr(),     "lw_maddr");
        step(JUNK,  1, e_mrd(),       "lw_mrd");
        step(JUNK,  1, e_mwb(),       "lw_mwb");

        // sw with three wait cycles in MWR
        step(JUNK,  1, e_fetch(1),    "sw_fetch");
        step(OP_SW, 1, e_decode(0),   "sw_decode");
        step(JUNK,  1, e_maddr(),     "sw_maddr");
        step(JUNK,  0, e_mwr(0),      "sw_wait1");
        step(JUNK,  0, e_mwr(0),      "sw_wait2");
        step(JUNK,  0, e_mwr(0),      "sw_wait3");
        step(JUNK,  1, e_mwr(1),      "sw_ready");

        // beq
        step(JUNK,   1, e_fetch(1),   "beq_fetch");
        step(OP_BEQ, 1, e_decode(0),  "beq_decode");
        step(JUNK,   1, e_beq(),      "beq_exec");

        // ori then jal
        step(JUNK,   1, e_fetch(1),       "ori_fetch");
        step(OP_ORI, 1, e_decode(0),      "ori_decode");
        step(JUNK,   1, e_iexec(3'b101),  "ori_iexec");
        step(JUNK,   1, e_iwb(),          "ori_iwb");
        step(JUNK,   1, e_fetch(1),       "jal_fetch");
        step(OP_JAL, 1, e_decode(0),      "jal_decode");
        step(JUNK,   1, e_jal(),          "jal_exec");

        // R-type with one fetch wait
        step(JUNK,     0, e_fetch(0),     "r_fetch_wait");
        step(JUNK,     1, e_fetch(1),     "r_fetch");
        step(OP_RTYPE, 1, e_decode(0),    "r_decode");
        step(JUNK,     1, e_rexec(),      "r_rexec");
        step(JUNK,     1, e_rwb(),        "r_rwb");

        // andi and addi select their own ALUOp
        step(JUNK,    1, e_fetch(1),      "andi_fetch");
        step(OP_ANDI, 1, e_decode(0),     "andi_decode");
        step(JUNK,    1, e_iexec(3'b100), "andi_iexec");
        step(JUNK,    1, e_iwb(),         "andi_iwb");
        step(JUNK,    1, e_fetch(1),      "addi_fetch");
        step(OP_ADDI, 1, e_decode(0),     "addi_decode");
        step(JUNK,    1, e_iexec(3'b000), "addi_iexec");
        step(JUNK,    1, e_iwb(),         "addi_iwb");

        // lw abandoned by reset while waiting in MRD
        step(JUNK,  1, e_fetch(1),  "lwr_fetch");
        step(OP_LW, 1, e_decode(0), "lwr_decode");
        step(JUNK,  1, e_maddr(),   "lwr_maddr");
        step(JUNK,  0, e_mrd(),     "lwr_mrd_wait");
        rst_n = 1'b0;
        step(JUNK,  1, e_zero(),    "lwr_reset_outputs");
        check_state_reset("lwr_reset_state");
        rst_n = 1'b1;
        step(JUNK,  1, e_zero(),    "lwr_release");
        step(JUNK,  1, e_fetch(1),  "lwr_refetch");

        // unknown opcode
`ifdef ILLEGAL_OP_TRAP_EN
        step(JUNK, 1, e_decode(0), "ill_decode");
        step(JUNK, 1, e_trap(),    "ill_trap1");
        step(OP_LW, 1, e_trap(),   "ill_trap2");
        step(JUNK, 1, e_trap(),    "ill_trap3");
        rst_n = 1'b0;
        step(JUNK, 1, e_zero(),    "ill_reset");
        check_state_reset("ill_reset_state");
        rst_n = 1'b1;
        step(JUNK, 1, e_zero(),    "ill_release");
        step(JUNK, 1, e_fetch(1),  "ill_refetch");
`else
        step(JUNK, 1, e_decode(1), "nop_decode");
        step(JUNK, 1, e_fetch(1),  "nop_refetch");
        step(OP_BEQ, 1, e_decode(0), "nop_next_decode");
        step(JUNK, 1, e_beq(),     "nop_next_beq");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
